// File: rtl/rf_arb_pkg.sv
// Shared constants and the round-robin search function for the register file
// write arbiter.
package rf_arb_pkg;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

  // The search runs over a fixed 8-wide vector so one function serves every NREQ.
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDX_W    = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First requesting index at or above ptr, wrapping at nreq-1 -> 0.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                       input logic [IDX_W-1:0]    ptr,
                                       input int unsigned         nreq);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      j = (32'(ptr) + k) % nreq;
      if (k < nreq && !res.found && req[j[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_addr_onehot.sv
// Combinational address to one-hot write-enable decode, gated by an enable.
module rf_addr_onehot #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic                   i_en,
  output logic [2**ADDR_W-1:0]   o_onehot
);

  // Single bit set at the addressed position only while enabled.
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter and one-cycle write sequencer for the register file write port.
// Optional feature: define RFARB_URGENT_EN to add the 'urgent' input, which lets
// requester 0 win without advancing the round-robin pointer.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
`ifdef RFARB_URGENT_EN
  input  logic                     urgent,
`endif
  input  logic                     stall,
  output logic [NREQ-1:0]          gnt,
  output logic                     wr_valid,
  output logic [2**ADDR_W-1:0]     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [$clog2(NREQ)-1:0]  wr_src
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned SRC_W = $clog2(NREQ);

  logic [MAX_NREQ-1:0] w_req_ext;
  rr_pick_t            w_pick;
  logic                w_urgent_win;
  logic                w_xfer;
  logic [IDX_W-1:0]    w_idx;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic [SRC_W-1:0]    w_ptr_d;
  logic [DEPTH-1:0]    w_wr_en;

  logic [SRC_W-1:0]    r_ptr;
  logic                r_wr_valid;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [SRC_W-1:0]    r_wr_src;

  // Winner selection: urgent override (if built in) ahead of round-robin; stall blocks all.
  always_comb begin
    w_req_ext = '0;
    w_req_ext[NREQ-1:0] = req;
    w_pick = rr_pick(w_req_ext, IDX_W'(r_ptr), NREQ);
`ifdef RFARB_URGENT_EN
    w_urgent_win = urgent & req[0];
`else
    w_urgent_win = 1'b0;
`endif
    w_idx  = w_urgent_win ? '0 : w_pick.idx;
    w_xfer = ~stall & (w_urgent_win | w_pick.found);
  end

  // One-hot grant; a grant always coincides with a transfer.
  always_comb begin
    gnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_xfer && (w_idx == IDX_W'(i))) gnt[i] = 1'b1;
    end
  end

  // Payload mux selecting the winner's address and data.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer moves just past the winner; urgent grants leave the rotation untouched.
  always_comb begin
    w_ptr_d = r_ptr;
    if (w_xfer && !w_urgent_win) begin
      w_ptr_d = (w_idx == IDX_W'(NREQ - 1)) ? '0 : SRC_W'(w_idx + IDX_W'(1));
    end
  end

  // Pointer and output stage; payload fields hold when no transfer occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_src   <= '0;
    end else begin
      r_ptr      <= w_ptr_d;
      r_wr_valid <= w_xfer;
      if (w_xfer) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
        r_wr_src  <= SRC_W'(w_idx);
      end
    end
  end

  // Enables derive only from registers, so an async reset clears them at once.
  rf_addr_onehot #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .i_addr   (r_wr_addr),
    .i_en     (r_wr_valid),
    .o_onehot (w_wr_en)
  );

  assign wr_valid = r_wr_valid;
  assign wr_en    = w_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_src   = r_wr_src;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. The urgent test is included when
// RFARB_URGENT_EN is defined for both bench and design.
module tb_rf_write_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int SRC_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic                   stall = 1'b0;
  logic                   urgent = 1'b0;
  logic [NREQ-1:0]        gnt;
  logic                   wr_valid;
  logic [DEPTH-1:0]       wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [SRC_W-1:0]       wr_src;

  rf_write_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
`ifdef RFARB_URGENT_EN
    .urgent   (urgent),
`endif
    .stall    (stall),
    .gnt      (gnt),
    .wr_valid (wr_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_src   (wr_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } wr_t;

  wr_t exp_q[$];
  int  m_ptr = 0;
  bit  mon_en = 1'b0;
  int  total = 0;
  int  bad = 0;

  // Reference arbitration: stall, then urgent override, then round-robin from p.
  function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] r, input logic st,
                                                input logic urg, input int p);
    logic [NREQ-1:0] g;
    int j;
    g = '0;
    if (st) return g;
`ifdef RFARB_URGENT_EN
    if (urg && r[0]) begin
      g[0] = 1'b1;
      return g;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      j = (p + k) % NREQ;
      if (r[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Record the expected write for an accepted grant and advance the model pointer.
  task automatic commit(input logic [NREQ-1:0] g);
    wr_t e;
    bit  urg_win;
    urg_win = 1'b0;
`ifdef RFARB_URGENT_EN
    urg_win = urgent && req[0];
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        e.addr = req_addr[i*ADDR_W +: ADDR_W];
        e.data = req_data[i*DATA_W +: DATA_W];
        e.src  = SRC_W'(i);
        exp_q.push_back(e);
        if (!urg_win) m_ptr = (i + 1) % NREQ;
      end
    end
  endtask

  task automatic set_payload(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Scoreboard: one cycle after each accepted grant the write must appear, else idle.
  always @(posedge clk) begin
    wr_t              e;
    logic [DEPTH-1:0] en_exp;
    #1;
    if (mon_en) begin
      total++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        en_exp = '0;
        en_exp[e.addr] = 1'b1;
        if (wr_valid !== 1'b1 || wr_en !== en_exp || wr_addr !== e.addr ||
            wr_data !== e.data || wr_src !== e.src) begin
          bad++;
          $display("FAIL write: got v=%b en=%b a=%0d d=%h s=%0d, want v=1 en=%b a=%0d d=%h s=%0d",
                   wr_valid, wr_en, wr_addr, wr_data, wr_src, en_exp, e.addr, e.data, e.src);
        end
      end else if (wr_valid !== 1'b0 || wr_en !== '0) begin
        bad++;
        $display("FAIL idle: got v=%b en=%b, want v=0 en=0", wr_valid, wr_en);
      end
    end
  end

  task automatic test_reset();
    #1;
    total++;
    if (wr_valid !== 1'b0 || wr_en !== '0 || wr_addr !== '0 || wr_data !== '0 ||
        wr_src !== '0 || gnt !== '0) begin
      bad++;
      $display("FAIL reset: got v=%b en=%b a=%0d d=%h s=%0d g=%b, want all 0",
               wr_valid, wr_en, wr_addr, wr_data, wr_src, gnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] exp;
    @(negedge clk);
    req = 4'b0001;
    set_payload(0, 3'd5, 16'hBEEF);
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL single_gnt: got %b want 0001", gnt);
    end
    commit(exp);
    @(posedge clk);
    #2;
    total++;
    if (wr_en !== 8'b0010_0000 || wr_data !== 16'hBEEF || wr_src !== 2'd0) begin
      bad++;
      $display("FAIL single_write: got en=%b d=%h s=%0d want en=00100000 d=beef s=0",
               wr_en, wr_data, wr_src);
    end
  endtask

  task automatic test_rr_all();
    logic [NREQ-1:0] exp;
    logic [NREQ-1:0] want_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    // Requester 3 alone first, which brings the pointer back to 0.
    @(negedge clk);
    req = 4'b1000;
    set_payload(3, 3'd2, 16'h0303);
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    total++;
    if (gnt !== exp) begin
      bad++;
      $display("FAIL rr_prep: got %b want %b", gnt, exp);
    end
    commit(exp);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_payload(i, ADDR_W'((i * 3 + c) % 8), DATA_W'($urandom));
      #1;
      exp = model_gnt(req, stall, urgent, m_ptr);
      total++;
      if (gnt !== want_seq[c]) begin
        bad++;
        $display("FAIL rr_all[%0d]: got %b want %b", c, gnt, want_seq[c]);
      end
      commit(exp);
    end
  endtask

  task automatic test_rr_sparse();
    logic [NREQ-1:0] exp;
    logic [NREQ-1:0] want_seq [3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [NREQ-1:0] req_seq  [3] = '{4'b0010, 4'b1010, 4'b1010};
    // First grant to requester 1 leaves ptr=2; then 1010 must go 3 then 1.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req = req_seq[c];
      set_payload(1, 3'd0, DATA_W'(16'h1100 + c));
      set_payload(3, 3'd7, DATA_W'(16'h3300 + c));
      #1;
      exp = model_gnt(req, stall, urgent, m_ptr);
      total++;
      if (gnt !== want_seq[c]) begin
        bad++;
        $display("FAIL rr_sparse[%0d]: got %b want %b", c, gnt, want_seq[c]);
      end
      commit(exp);
    end
  endtask

  task automatic test_stall();
    logic [NREQ-1:0] exp;
    // Requester 0 alone moves ptr to 1 before the stall window.
    @(negedge clk);
    req = 4'b0001;
    set_payload(0, 3'd4, 16'h0A0A);
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    commit(exp);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req = 4'b0110;
      stall = 1'b1;
      set_payload(1, 3'd1, 16'h5151);
      set_payload(2, 3'd6, 16'h6262);
      #1;
      exp = model_gnt(req, stall, urgent, m_ptr);
      total++;
      if (gnt !== 4'b0000) begin
        bad++;
        $display("FAIL stall[%0d]: got %b want 0000", c, gnt);
      end
      commit(exp);
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL stall_release: got %b want 0010", gnt);
    end
    commit(exp);
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp;
    // Requester 2 keeps asserting with fresh payloads; 0 and 2 must alternate.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req = 4'b0101;
      set_payload(0, ADDR_W'(c), DATA_W'(16'hC000 + c));
      set_payload(2, ADDR_W'(7 - c), DATA_W'(16'hD000 + c));
      #1;
      exp = model_gnt(req, stall, urgent, m_ptr);
      total++;
      if (gnt !== exp) begin
        bad++;
        $display("FAIL b2b[%0d]: got %b want %b", c, gnt, exp);
      end
      commit(exp);
    end
  endtask

  task automatic test_async_reset();
    logic [NREQ-1:0] exp;
    @(negedge clk);
    req = 4'b0100;
    set_payload(2, 3'd3, 16'h1234);
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    commit(exp);
    @(negedge clk);
    req = '0;
    total++;
    if (wr_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid: got %b want 1", wr_valid);
    end
    #1;
    rst_n = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    #1;
    total++;
    if (wr_valid !== 1'b0 || wr_en !== '0 || wr_data !== '0) begin
      bad++;
      $display("FAIL async_reset: got v=%b en=%b d=%h want v=0 en=0 d=0",
               wr_valid, wr_en, wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    req = 4'b0100;
    set_payload(2, 3'd6, 16'h2222);
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL post_reset_gnt: got %b want 0100", gnt);
    end
    commit(exp);
  endtask

`ifdef RFARB_URGENT_EN
  task automatic test_urgent();
    logic [NREQ-1:0] exp;
    // Requester 1 alone sets ptr=2 before the urgent override.
    @(negedge clk);
    req = 4'b0010;
    set_payload(1, 3'd2, 16'h7777);
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    commit(exp);
    @(negedge clk);
    req = 4'b0101;
    urgent = 1'b1;
    set_payload(0, 3'd1, 16'hAAAA);
    set_payload(2, 3'd5, 16'hBBBB);
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL urgent_gnt: got %b want 0001", gnt);
    end
    commit(exp);
    @(negedge clk);
    urgent = 1'b0;
    #1;
    exp = model_gnt(req, stall, urgent, m_ptr);
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL urgent_ptr_hold: got %b want 0100", gnt);
    end
    commit(exp);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_rr_sparse();
    test_stall();
    test_back_to_back();
    test_async_reset();
`ifdef RFARB_URGENT_EN
    test_urgent();
`endif
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter and sequencer for the single write port of the 8-entry register file. It accepts write requests from up to NREQ requesters over a valid/grant handshake and selects one per cycle. The winner's address is decoded into the one-hot per-register write-enable vector, and the write is presented to the register file one cycle after acceptance. The block sits between the datapath requesters (ALU writeback, load unit, etc.) and the register file write port.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 16, register data width
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W = 8
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  request valid, one bit per requester
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i in bits [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed data; requester i in bits [i*DATA_W +: DATA_W]
- stall  in  1  register file busy; no grants while high
- gnt  out  NREQ  combinational one-hot grant
- wr_valid  out  1  registered write strobe
- wr_en  out  DEPTH  registered one-hot write enable (decoded wr_addr), 0 when !wr_valid
- wr_addr  out  ADDR_W  registered write address
- wr_data  out  DATA_W  registered write data
- wr_src  out  $clog2(NREQ)  index of the requester that produced the current write

## Operation
- Handshake: a transfer occurs on a rising edge when req[i] & gnt[i]. Requester i holds req, addr and data stable until that edge. Dropping req before the grant is legal and withdraws the request.
- gnt is at most one-hot and is 0 when stall=1 or req=0.
- Round-robin: pointer ptr, reset 0. The search starts at ptr and proceeds upward, wrapping at NREQ-1→0. The first requesting index wins.
- After a transfer from i, ptr ← (i+1) mod NREQ. ptr is unchanged on cycles with no transfer.
- Output stage: on a transfer, wr_valid←1, wr_addr←addr_i, wr_data←data_i, wr_src←i, wr_en←onehot(addr_i). Without a transfer, wr_valid←0 and wr_en←0; wr_addr/wr_data/wr_src hold their values.
- Decode: wr_en[k]=1 iff k==wr_addr and wr_valid. Exactly one bit is set per valid write.
- Address 0 is not special; writes to it pass through.
- Simultaneous stall and req: stall wins, no grant, ptr holds.
- A requester may issue back-to-back transfers (req held, new payload after each grant). Round-robin still interleaves it with other requesters.

## Timing
- Reset (async assert, sync release on clk): ptr=0, wr_valid=0, wr_en=0, wr_addr=0, wr_data=0, wr_src=0.
- gnt has zero-cycle latency from req/stall/ptr (combinational).
- Write latency: transfer at edge N → wr_valid/wr_en visible for the cycle after edge N. The register file captures the write at edge N+1.
- Throughput: one write per cycle.
- Reset mid-operation: an in-flight wr_valid is cleared immediately (write dropped), and ptr returns to 0.

## Configuration
- RFARB_URGENT_EN defined: adds input port urgent (1 bit). When urgent=1 and req[0]=1 and stall=0, requester 0 wins regardless of ptr, and ptr is NOT updated by that grant. When urgent=1 and req[0]=0, normal round-robin applies.
- RFARB_URGENT_EN undefined: no urgent port; pure round-robin.

## Structure
- Package rf_arb_pkg: default NREQ/DATA_W/ADDR_W constants, DEPTH localparam derivation, and a function rr_pick(req, ptr) returning the winning index plus a found flag.
- Sub-module rf_addr_onehot (parameter ADDR_W): combinational address→one-hot DEPTH decode with an enable input. It is instantiated once on the registered wr_addr/wr_valid.
- Top module holds ptr, the output registers and the handshake logic.

## Test plan
- Reset, then req[0]=1, addr=5, data=16'hBEEF → gnt=4'b0001 same cycle; next cycle wr_valid=1, wr_en=8'b0010_0000, wr_data=16'hBEEF, wr_src=0.
- req=4'b1111 held for 5 cycles, stall=0 → grant order 0,1,2,3,0; ptr=1 afterwards.
- req=4'b1010 with ptr=2 → grants 3 then 1. wr_en tracks each address, e.g. addr 7 → 8'b1000_0000 and addr 0 → 8'b0000_0001.
- stall=1 for 3 cycles with req=4'b0110 → gnt=0, wr_valid=0, ptr unchanged. After stall drops, requester 1 is granted first (ptr=1).
- Assert rst_n=0 while wr_valid=1 → wr_valid and wr_en go to 0 without waiting for clk; after release, req[2] alone → gnt=4'b0100.
- With RFARB_URGENT_EN: ptr=2, req=4'b0101, urgent=1 → gnt=4'b0001 and ptr stays 2. Next cycle with urgent=0 → gnt=4'b0100.
